warp_fetch_arbiter: RTL and testbench

WARP_FETCH_ARBITER -- requirements
Module: warp_fetch_arbiter

---
 rtl/warp_fetch_arbiter.sv | 154 +++++++++++++++
 tb/tb_warp_fetch_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetch_arbiter.sv
// Round-robin instruction fetch arbiter for NUM_WARPS warps with per-warp in-flight
// accounting and flush-driven response dropping. Optional perf counters: FETCH_ARB_PERF_EN.
module warp_fetch_arbiter #(
  parameter int ARCH_LEN     = 32,
  parameter int NUM_WARPS    = 8,
  parameter int INST_BITS    = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           fetch_req_valid,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]  fetch_req_pc,
  output logic [NUM_WARPS-1:0]           fetch_req_ready,
  input  logic [NUM_WARPS-1:0]           flush,
  input  logic                           imem_req_ready,
  output logic                           imem_req_valid,
  output logic [ARCH_LEN-1:0]            imem_req_bits_address,
  output logic [5:0]                     imem_req_bits_tag,
  output logic [1:0]                     imem_req_bits_size,
  output logic                           imem_req_bits_store,
  output logic                           imem_resp_ready,
  input  logic                           imem_resp_valid,
  input  logic [5:0]                     imem_resp_bits_tag,
  input  logic [INST_BITS-1:0]           imem_resp_bits_data,
  output logic [NUM_WARPS-1:0]           fetch_resp_valid,
  input  logic [NUM_WARPS-1:0]           fetch_resp_ready,
  output logic [NUM_WARPS*INST_BITS-1:0] fetch_resp_data
`ifdef FETCH_ARB_PERF_EN
  ,
  output logic [31:0]                    perf_grants,
  output logic [31:0]                    perf_stalls
`endif
);

  localparam int WID = $clog2(NUM_WARPS);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [WID-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        inflight_q [NUM_WARPS];
  logic [CW-1:0]        inflight_d [NUM_WARPS];
  logic [CW-1:0]        drop_cnt_q [NUM_WARPS];
  logic [CW-1:0]        drop_cnt_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] warp_inc, warp_dec;
  logic                 grant_found;
  logic [WID-1:0]       grant_id;
  logic [WID-1:0]       resp_id;
  logic                 resp_dropping;
  logic                 req_fire, resp_fire;
  logic                 unused_tag_hi;

  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = fetch_req_valid[w] && !flush[w] && (inflight_q[w] < MAX_CNT) && !reset;
    end
  end

  // Scan starts at rr_ptr; the pointer wraps naturally since NUM_WARPS is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!grant_found && eligible[rr_ptr_q + WID'(i)]) begin
        grant_found = 1'b1;
        grant_id    = rr_ptr_q + WID'(i);
      end
    end
  end

  assign imem_req_valid        = grant_found;
  assign imem_req_bits_address = fetch_req_pc[ARCH_LEN*int'(grant_id) +: ARCH_LEN];
  assign imem_req_bits_tag     = 6'(grant_id);
  assign imem_req_bits_size    = 2'd3;
  assign imem_req_bits_store   = 1'b0;
  assign req_fire              = grant_found && imem_req_ready;

  always_comb begin
    fetch_req_ready = '0;
    if (req_fire) fetch_req_ready[grant_id] = 1'b1;
  end

  assign resp_id         = imem_resp_bits_tag[WID-1:0];
  assign unused_tag_hi   = ^imem_resp_bits_tag[5:WID];
  assign resp_dropping   = drop_cnt_q[resp_id] != '0;
  assign imem_resp_ready = reset || resp_dropping || fetch_resp_ready[resp_id];
  assign resp_fire       = imem_resp_valid && imem_resp_ready;
  assign fetch_resp_data = {NUM_WARPS{imem_resp_bits_data}};

  always_comb begin
    fetch_resp_valid = '0;
    if (imem_resp_valid && !resp_dropping && !reset) fetch_resp_valid[resp_id] = 1'b1;
  end

  // A response for a warp with nothing in flight is a protocol error and leaves counters alone.
  always_comb begin
    rr_ptr_d = req_fire ? grant_id + WID'(1) : rr_ptr_q;
    warp_inc = '0;
    warp_dec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_inc[w]   = req_fire && (grant_id == WID'(w));
      warp_dec[w]   = resp_fire && (resp_id == WID'(w)) && (inflight_q[w] != '0);
      inflight_d[w] = inflight_q[w];
      drop_cnt_d[w] = drop_cnt_q[w];
      if (warp_inc[w] && !warp_dec[w]) inflight_d[w] = inflight_q[w] + CW'(1);
      else if (warp_dec[w] && !warp_inc[w]) inflight_d[w] = inflight_q[w] - CW'(1);
      if (warp_dec[w] && drop_cnt_q[w] != '0) drop_cnt_d[w] = drop_cnt_q[w] - CW'(1);
      if (flush[w]) drop_cnt_d[w] = inflight_d[w];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        inflight_q[w] <= '0;
        drop_cnt_q[w] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        inflight_q[w] <= inflight_d[w];
        drop_cnt_q[w] <= drop_cnt_d[w];
      end
    end
  end

`ifdef FETCH_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stalls_d = perf_stalls_q;
    if (req_fire && perf_grants_q != '1) perf_grants_d = perf_grants_q + 32'd1;
    if (imem_req_valid && !imem_req_ready && perf_stalls_q != '1) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_warp_fetch_arbiter.sv
// Self-checking bench for warp_fetch_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a warp-level reference model.
module tb_warp_fetch_arbiter;

  localparam int NW = 8;
  localparam int AL = 32;
  localparam int IB = 64;
  localparam int MI = 2;

  logic              clock;
  logic              reset;
  logic [NW-1:0]     fetch_req_valid;
  logic [NW*AL-1:0]  fetch_req_pc;
  logic [NW-1:0]     fetch_req_ready;
  logic [NW-1:0]     flush;
  logic              imem_req_ready;
  logic              imem_req_valid;
  logic [AL-1:0]     imem_req_bits_address;
  logic [5:0]        imem_req_bits_tag;
  logic [1:0]        imem_req_bits_size;
  logic              imem_req_bits_store;
  logic              imem_resp_ready;
  logic              imem_resp_valid;
  logic [5:0]        imem_resp_bits_tag;
  logic [IB-1:0]     imem_resp_bits_data;
  logic [NW-1:0]     fetch_resp_valid;
  logic [NW-1:0]     fetch_resp_ready;
  logic [NW*IB-1:0]  fetch_resp_data;
`ifdef FETCH_ARB_PERF_EN
  logic [31:0]       perf_grants;
  logic [31:0]       perf_stalls;
  longint            m_grants;
  longint            m_stalls;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  int m_infl [NW];
  int m_drop [NW];
  int m_rr;

  logic [5:0]    obs_tag;
  logic [AL-1:0] obs_addr;
  logic          obs_req_valid;
  logic          obs_resp_ready;
  logic [NW-1:0] obs_frr;
  logic [NW-1:0] obs_frv;

  warp_fetch_arbiter #(
    .ARCH_LEN(AL), .NUM_WARPS(NW), .INST_BITS(IB), .MAX_INFLIGHT(MI)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .fetch_req_valid       (fetch_req_valid),
    .fetch_req_pc          (fetch_req_pc),
    .fetch_req_ready       (fetch_req_ready),
    .flush                 (flush),
    .imem_req_ready        (imem_req_ready),
    .imem_req_valid        (imem_req_valid),
    .imem_req_bits_address (imem_req_bits_address),
    .imem_req_bits_tag     (imem_req_bits_tag),
    .imem_req_bits_size    (imem_req_bits_size),
    .imem_req_bits_store   (imem_req_bits_store),
    .imem_resp_ready       (imem_resp_ready),
    .imem_resp_valid       (imem_resp_valid),
    .imem_resp_bits_tag    (imem_resp_bits_tag),
    .imem_resp_bits_data   (imem_resp_bits_data),
    .fetch_resp_valid      (fetch_resp_valid),
    .fetch_resp_ready      (fetch_resp_ready),
    .fetch_resp_data       (fetch_resp_data)
`ifdef FETCH_ARB_PERF_EN
    ,
    .perf_grants           (perf_grants),
    .perf_stalls           (perf_stalls)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < NW; w++) begin
      m_infl[w] = 0;
      m_drop[w] = 0;
    end
    m_rr = 0;
`ifdef FETCH_ARB_PERF_EN
    m_grants = 0;
    m_stalls = 0;
`endif
  endtask

  // One clock cycle: settle, compare every output against the model, then advance the model.
  task automatic applyStimulus();
    int            exp_grant;
    int            rid;
    bit            dropping;
    bit            exp_rr;
    bit            req_hs;
    bit            resp_hs;
    logic [NW-1:0] exp_frr;
    logic [NW-1:0] exp_frv;
    @(negedge clock);
    #1;
    exp_grant = -1;
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_rr + k) % NW;
      if (exp_grant < 0 && !reset && fetch_req_valid[w] && !flush[w] && m_infl[w] < MI) exp_grant = w;
    end
    checkOutput("imem_req_valid", 64'(imem_req_valid), 64'(exp_grant >= 0));
    if (exp_grant >= 0) begin
      checkOutput("imem_req_tag", 64'(imem_req_bits_tag), 64'(exp_grant));
      checkOutput("imem_req_addr", 64'(imem_req_bits_address), 64'(fetch_req_pc[exp_grant*AL +: AL]));
      checkOutput("imem_req_size_store", 64'({imem_req_bits_size, imem_req_bits_store}), 64'(3'b110));
    end
    req_hs  = exp_grant >= 0 && imem_req_ready;
    exp_frr = req_hs ? (NW'(1) << exp_grant) : '0;
    checkOutput("fetch_req_ready", 64'(fetch_req_ready), 64'(exp_frr));
    rid      = int'(imem_resp_bits_tag) % NW;
    dropping = m_drop[rid] > 0;
    exp_rr   = reset || dropping || fetch_resp_ready[rid];
    checkOutput("imem_resp_ready", 64'(imem_resp_ready), 64'(exp_rr));
    exp_frv = (!reset && imem_resp_valid && !dropping) ? (NW'(1) << rid) : '0;
    checkOutput("fetch_resp_valid", 64'(fetch_resp_valid), 64'(exp_frv));
    if (imem_resp_valid) begin
      checkOutput("fetch_resp_data", fetch_resp_data[rid*IB +: IB], imem_resp_bits_data);
      checkOutput("fetch_resp_data_other", fetch_resp_data[((rid+1)%NW)*IB +: IB], imem_resp_bits_data);
    end
    resp_hs = imem_resp_valid && exp_rr;
`ifdef FETCH_ARB_PERF_EN
    checkOutput("perf_grants", 64'(perf_grants), 64'(m_grants));
    checkOutput("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif
    obs_tag        = imem_req_bits_tag;
    obs_addr       = imem_req_bits_address;
    obs_req_valid  = imem_req_valid;
    obs_resp_ready = imem_resp_ready;
    obs_frr        = fetch_req_ready;
    obs_frv        = fetch_resp_valid;
    if (reset) begin
      modelReset();
    end else begin
      if (resp_hs && m_infl[rid] > 0) begin
        m_infl[rid]--;
        if (m_drop[rid] > 0) m_drop[rid]--;
      end
      if (req_hs) begin
        m_infl[exp_grant]++;
        m_rr = (exp_grant + 1) % NW;
      end
`ifdef FETCH_ARB_PERF_EN
      if (req_hs) m_grants++;
      if (exp_grant >= 0 && !imem_req_ready) m_stalls++;
`endif
      for (int w = 0; w < NW; w++) begin
        if (flush[w]) m_drop[w] = m_infl[w];
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    fetch_req_valid     = '0;
    flush               = '0;
    imem_req_ready      = 1'b1;
    imem_resp_valid     = 1'b0;
    imem_resp_bits_tag  = '0;
    imem_resp_bits_data = 64'hDEAD_BEEF_0000_0000;
    fetch_resp_ready    = '0;
    for (int w = 0; w < NW; w++) fetch_req_pc[w*AL +: AL] = 32'h0000_1000 + 32'(w) * 32'h100;
  endtask

  task automatic applyReset();
    idleInputs();
    reset               = 1'b1;
    fetch_req_valid     = 8'hFF;
    imem_resp_valid     = 1'b1;
    imem_resp_bits_tag  = 6'd3;
    applyStimulus();
    checkOutput("reset_req_valid", 64'(obs_req_valid), 64'(0));
    checkOutput("reset_resp_ready", 64'(obs_resp_ready), 64'(1));
    checkOutput("reset_fetch_resp_valid", 64'(obs_frv), 64'(0));
    applyStimulus();
    reset = 1'b0;
    idleInputs();
  endtask

  task automatic randomizeInputs();
    int cands [$];
    reset            = ($urandom_range(0, 99) == 0);
    fetch_req_valid  = NW'($urandom);
    flush            = NW'($urandom & $urandom & $urandom & $urandom);
    imem_req_ready   = ($urandom_range(0, 3) != 0);
    fetch_resp_ready = NW'($urandom);
    for (int w = 0; w < NW; w++) fetch_req_pc[w*AL +: AL] = $urandom;
    imem_resp_bits_data = {$urandom, $urandom};
    for (int w = 0; w < NW; w++) if (m_infl[w] > 0) cands.push_back(w);
    if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
      imem_resp_valid    = 1'b1;
      imem_resp_bits_tag = 6'(cands[$urandom_range(0, cands.size() - 1)]);
    end else begin
      imem_resp_valid    = 1'b0;
      imem_resp_bits_tag = 6'($urandom_range(0, NW - 1));
    end
  endtask

  initial begin
    int seq [6];
    seq = '{0, 3, 5, 0, 3, 5};
    reset = 1'b1;
    idleInputs();
    modelReset();
    @(posedge clock);
    #1;
    applyReset();

    $display("[TB] round-robin over warps 0,3,5");
    fetch_req_valid = 8'b0010_1001;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("rr_grant_seq", 64'(obs_tag), 64'(seq[i]));
    end
    applyStimulus();
    checkOutput("rr_all_full", 64'(obs_req_valid), 64'(0));

    $display("[TB] in-flight limit on warp 2");
    applyReset();
    fetch_req_valid = 8'b0000_0100;
    applyStimulus();
    applyStimulus();
    checkOutput("limit_second_grant", 64'(obs_frr), 64'(8'h04));
    applyStimulus();
    applyStimulus();
    checkOutput("limit_blocked", 64'(obs_frr), 64'(0));
    imem_resp_valid     = 1'b1;
    imem_resp_bits_tag  = 6'd2;
    fetch_resp_ready[2] = 1'b1;
    applyStimulus();
    checkOutput("limit_resp_delivered", 64'(obs_frv), 64'(8'h04));
    imem_resp_valid = 1'b0;
    applyStimulus();
    checkOutput("limit_reopened", 64'(obs_frr), 64'(8'h04));

    $display("[TB] imem stall with warps 1 and 6");
    applyReset();
    fetch_req_valid = 8'b0100_0010;
    imem_req_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("stall_tag", 64'(obs_tag), 64'(1));
      checkOutput("stall_addr", 64'(obs_addr), 64'(32'h0000_1100));
    end
    imem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("stall_release", 64'(obs_frr), 64'(8'h02));
`ifdef FETCH_ARB_PERF_EN
    checkOutput("stall_perf", 64'(perf_stalls), 64'(4));
`endif
    applyStimulus();
    checkOutput("stall_next_rr", 64'(obs_tag), 64'(6));

    $display("[TB] flush drops outstanding responses on warp 4");
    applyReset();
    fetch_req_valid = 8'b0001_0000;
    applyStimulus();
    applyStimulus();
    fetch_req_valid = '0;
    flush[4] = 1'b1;
    applyStimulus();
    flush[4]           = 1'b0;
    imem_resp_valid    = 1'b1;
    imem_resp_bits_tag = 6'd4;
    applyStimulus();
    checkOutput("flush_drop1_ready", 64'(obs_resp_ready), 64'(1));
    checkOutput("flush_drop1_valid", 64'(obs_frv), 64'(0));
    imem_resp_valid = 1'b0;
    fetch_req_valid = 8'b0001_0000;
    applyStimulus();
    checkOutput("flush_refetch", 64'(obs_frr), 64'(8'h10));
    fetch_req_valid = '0;
    imem_resp_valid = 1'b1;
    applyStimulus();
    checkOutput("flush_drop2_ready", 64'(obs_resp_ready), 64'(1));
    checkOutput("flush_drop2_valid", 64'(obs_frv), 64'(0));
    fetch_resp_ready[4] = 1'b1;
    applyStimulus();
    checkOutput("flush_third_delivered", 64'(obs_frv), 64'(8'h10));
    imem_resp_valid = 1'b0;

    $display("[TB] same-cycle grant and response on warp 6");
    applyReset();
    fetch_req_valid = 8'b0100_0000;
    applyStimulus();
    imem_resp_valid     = 1'b1;
    imem_resp_bits_tag  = 6'd6;
    fetch_resp_ready[6] = 1'b1;
    applyStimulus();
    checkOutput("same_cycle_grant", 64'(obs_frr), 64'(8'h40));
    checkOutput("same_cycle_resp", 64'(obs_frv), 64'(8'h40));
    imem_resp_valid = 1'b0;
    applyStimulus();
    checkOutput("same_cycle_one_left", 64'(obs_frr), 64'(8'h40));
    applyStimulus();
    checkOutput("same_cycle_now_full", 64'(obs_frr), 64'(0));

    $display("[TB] reset with fetches in flight");
    applyReset();
    fetch_req_valid = 8'b0001_0110;
    for (int i = 0; i < 3; i++) applyStimulus();
    applyReset();
    fetch_req_valid = 8'b0100_1000;
    applyStimulus();
    checkOutput("post_reset_first", 64'(obs_tag), 64'(3));
    applyStimulus();
    checkOutput("post_reset_second", 64'(obs_tag), 64'(6));

    $display("[TB] randomized traffic");
    applyReset();
    for (int i = 0; i < 400; i++) begin
      randomizeInputs();
      applyStimulus();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
